// File: rtl/ln_pkg.sv
// ln_pkg: shared FSM state type and width constants for the LayerNorm row scheduler.
package ln_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  localparam int MATRIX_SIZE_DEF = 64;
  localparam int TC_W = 16;
endpackage

// File: rtl/ln_row_scheduler_if.sv
// ln_row_scheduler_if: row issue handshake, in-order result return and output-buffer write port.
interface ln_row_scheduler_if #(parameter int ROW_W = 6) ();
  logic issue_valid, issue_ready, result_valid, row_wr_en;
  logic [ROW_W-1:0] issue_row, result_row, row_wr_addr;
  modport master (output issue_valid, issue_row, row_wr_en, row_wr_addr,
                  input issue_ready, result_valid, result_row);
  modport slave (input issue_valid, issue_row, row_wr_en, row_wr_addr,
                 output issue_ready, result_valid, result_row);
endinterface

// File: rtl/ln_inflight_ctr.sv
// ln_inflight_ctr: up/down credit counter of rows issued but not yet completed.
module ln_inflight_ctr #(parameter int MAX = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic [$clog2(MAX+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int CW = $clog2(MAX+1);
  logic inc_ok, dec_ok;
  always_comb begin
    full = count == CW'(MAX);
    empty = count == '0;
    inc_ok = inc && !full;
    dec_ok = dec && !empty;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc_ok && !dec_ok) count <= count + 1'b1;
    else if (dec_ok && !inc_ok) count <= count - 1'b1;
  end
endmodule

// File: rtl/ln_row_scheduler.sv
// ln_row_scheduler: issues matrix rows to a row engine under a credit limit and writes results back in order.
// Define LN_SCHED_PERF_EN to build the saturating per-matrix cycle counter behind total_cycles.
module ln_row_scheduler import ln_pkg::*; #(
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int MAX_INFLIGHT = 4,
  parameter int ROW_W = $clog2(MATRIX_SIZE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_matrix,
  input  logic abort,
  ln_row_scheduler_if.master bus,
  output logic busy,
  output logic matrix_done,
  output logic seq_error,
  output logic [ROW_W-1:0] current_row_debug,
  output logic [TC_W-1:0] total_cycles
);
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(MATRIX_SIZE-1);
  state_e state, state_n;
  logic [ROW_W-1:0] issue_idx, exp_idx;
  logic [IW-1:0] inflight;
  logic full, empty, go, flush, clr, active, issue_fire, res_ok, res_bad;
  always_comb begin
    go = state == IDLE && start_matrix;
    flush = abort && state != IDLE;
    clr = go || flush;
    active = state == ISSUE || state == DRAIN;
    issue_fire = bus.issue_valid && bus.issue_ready;
    res_ok = bus.result_valid && active && !empty && bus.result_row == exp_idx;
    res_bad = bus.result_valid && !res_ok;
  end
  ln_inflight_ctr #(.MAX(MAX_INFLIGHT)) u_ctr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(issue_fire), .dec(res_ok),
    .count(inflight), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = flush ? IDLE :
              state == IDLE  ? (start_matrix ? ISSUE : IDLE) :
              state == ISSUE ? (issue_fire && issue_idx == LAST ? DRAIN : ISSUE) :
              state == DRAIN ? (res_ok && exp_idx == LAST && inflight == IW'(1) ? DONE : DRAIN) :
              IDLE;
  end
  always_comb begin
    bus.issue_valid = state == ISSUE && !full;
    bus.issue_row = issue_idx;
    bus.row_wr_en = res_ok;
    bus.row_wr_addr = res_ok ? bus.result_row : '0;
    busy = state != IDLE;
    matrix_done = state == DONE;
    current_row_debug = issue_idx;
  end
  // A stray result on the start cycle still flags, so the clear yields to a new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_idx <= '0;
      exp_idx <= '0;
      seq_error <= 1'b0;
    end else begin
      issue_idx <= clr ? '0 : issue_fire ? issue_idx + 1'b1 : issue_idx;
      exp_idx <= clr ? '0 : res_ok ? exp_idx + 1'b1 : exp_idx;
      seq_error <= (go ? 1'b0 : seq_error) | res_bad;
    end
  end
`ifdef LN_SCHED_PERF_EN
  logic [TC_W-1:0] cyc_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt <= '0;
    else if (go) cyc_cnt <= '0;
    else if (busy && !(&cyc_cnt)) cyc_cnt <= cyc_cnt + 1'b1;
  end
  assign total_cycles = cyc_cnt;
`else
  assign total_cycles = '0;
`endif
endmodule

// File: tb/tb_ln_row_scheduler.sv
// tb_ln_row_scheduler: directed bench for ln_row_scheduler with an in-order row-engine model.
module tb_ln_row_scheduler;
  localparam int N = 64;
  logic clk = 1'b0;
  logic rst_n, start_matrix, abort, busy, matrix_done, seq_error;
  logic [5:0] current_row_debug;
  logic [15:0] total_cycles;
  ln_row_scheduler_if #(.ROW_W(6)) bus ();
  ln_row_scheduler #(.MATRIX_SIZE(N), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_matrix(start_matrix), .abort(abort), .bus(bus),
    .busy(busy), .matrix_done(matrix_done), .seq_error(seq_error),
    .current_row_debug(current_row_debug), .total_cycles(total_cycles)
  );
  always #5 clk = ~clk;
  int tests, fails, cyc, lat, n_wr, n_issue, n_done;
  bit hold_res, toggle, inj, do_start, do_abort, stall_prev;
  logic [5:0] inj_row, row_prev;
  int q_row[$];
  int q_due[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic new_run();
    q_row.delete();
    q_due.delete();
    n_wr = 0; n_issue = 0; n_done = 0; stall_prev = 0;
  endtask
  // One clock: drive at negedge, sample settled outputs 1ns later, then let the posedge happen.
  task automatic cycle();
    @(negedge clk);
    start_matrix = do_start; abort = do_abort; do_start = 0; do_abort = 0;
    bus.issue_ready = toggle ? (cyc % 2 == 0) : 1'b1;
    if (inj) begin
      bus.result_valid = 1'b1; bus.result_row = inj_row; inj = 0;
    end else if (!hold_res && q_row.size() > 0 && q_due[0] <= cyc) begin
      bus.result_valid = 1'b1; bus.result_row = 6'(q_row.pop_front()); void'(q_due.pop_front());
    end else begin
      bus.result_valid = 1'b0; bus.result_row = '0;
    end
    #1;
    if (stall_prev) chk("stall_hold", {bus.issue_valid, bus.issue_row}, {1'b1, row_prev});
    if (bus.issue_valid && bus.issue_ready) begin
      chk("issue_seq", bus.issue_row, n_issue % N);
      q_row.push_back(int'(bus.issue_row)); q_due.push_back(cyc + lat);
      n_issue++;
    end
    stall_prev = bus.issue_valid && !bus.issue_ready;
    row_prev = bus.issue_row;
    if (bus.row_wr_en) begin
      chk("wr_addr", bus.row_wr_addr, n_wr % N);
      n_wr++;
    end
    if (matrix_done) n_done++;
    cyc++;
  endtask
  task automatic run_until_done(input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) cycle();
    chk("done_pulse", n_done, 1);
    chk("wr_count", n_wr, N);
    cycle();
    chk("done_one_cycle", {busy, matrix_done}, 2'b00);
  endtask
  initial begin
    tests = 0; fails = 0; cyc = 0; lat = 3;
    hold_res = 0; toggle = 0; inj = 0; do_start = 0; do_abort = 0; inj_row = '0;
    rst_n = 1'b0; start_matrix = 0; abort = 0;
    bus.issue_ready = 0; bus.result_valid = 0; bus.result_row = '0;
    new_run();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_wr_en", {bus.row_wr_en, bus.row_wr_addr}, 0);
    chk("rst_done", matrix_done, 0);
    chk("rst_seq_error", seq_error, 0);
    chk("rst_row_debug", current_row_debug, 0);
    chk("rst_total_cycles", total_cycles, 0);
    @(negedge clk) rst_n = 1'b1;
    // Latency-3 engine, ready always; a start pulse mid-matrix must be ignored.
    new_run(); do_start = 1;
    for (int k = 0; k < 30; k++) cycle();
    do_start = 1;
    run_until_done(300);
    chk("full_issue_count", n_issue, N);
    chk("full_seq_error", seq_error, 0);
    // Results withheld: only MAX_INFLIGHT rows go out.
    new_run(); lat = 1; hold_res = 1; do_start = 1;
    for (int k = 0; k < 11; k++) cycle();
    chk("credit_issued", n_issue, 4);
    chk("credit_valid_low", bus.issue_valid, 0);
    chk("credit_row_debug", current_row_debug, 4);
    hold_res = 0;
    run_until_done(300);
    // issue_ready toggling: stalled offers must hold.
    new_run(); lat = 2; toggle = 1; do_start = 1;
    run_until_done(400);
    chk("toggle_issue_count", n_issue, N);
    toggle = 0;
    // Out-of-order result: row 5 while 4 is expected.
    new_run(); lat = 1; do_start = 1;
    for (int k = 0; k < 20 && n_wr < 4; k++) cycle();
    inj = 1; inj_row = 6'd5;
    cycle();
    chk("bad_no_write", bus.row_wr_en, 0);
    cycle();
    chk("bad_seq_error", seq_error, 1);
    run_until_done(300);
    chk("bad_sticky", seq_error, 1);
    new_run(); do_start = 1;
    cycle(); cycle();
    chk("start_clears_err", seq_error, 0);
    run_until_done(300);
    // Abort after row 20 is issued, then a fresh matrix.
    new_run(); lat = 3; do_start = 1;
    for (int k = 0; k < 40 && n_issue < 21; k++) cycle();
    do_abort = 1;
    cycle(); cycle();
    chk("abort_idle", {busy, bus.issue_valid, matrix_done}, 3'b000);
    chk("abort_late_no_write", {bus.result_valid, bus.row_wr_en}, 2'b10);
    cycle();
    chk("abort_late_err", seq_error, 1);
    chk("abort_no_done", n_done, 0);
    new_run(); do_start = 1;
    run_until_done(300);
    chk("abort_restart_err", seq_error, 0);
    // Cycle counter with latency-1 results: 64 ISSUE + 1 DRAIN + 1 DONE.
    new_run(); lat = 1; do_start = 1;
    run_until_done(300);
`ifdef LN_SCHED_PERF_EN
    chk("total_cycles", total_cycles, 66);
`else
    chk("total_cycles", total_cycles, 0);
`endif
    // Reset mid-matrix.
    new_run(); do_start = 1;
    for (int k = 0; k < 10; k++) cycle();
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, matrix_done, bus.issue_valid, seq_error}, 4'b0000);
    chk("midrst_row_debug", current_row_debug, 0);
    @(negedge clk) rst_n = 1'b1;
    new_run();
    cycle(); cycle();
    chk("midrst_stays_idle", {busy, n_done[0]}, 2'b00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
